md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl_if.sv | 34 +++
 rtl/md_ctrl.sv | 86 ++++++++
 tb/tb_md_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_ctrl_if.sv
// HI/LO controller bundle: E-stage request side
// plus multiply/divide datapath handshake.
interface md_ctrl_if;
   logic        op_valid;
   logic [2:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        flush;
   logic [31:0] dp_hi;
   logic [31:0] dp_lo;
   logic        dp_start;
   logic [1:0]  dp_op;
   logic [31:0] dp_in1;
   logic [31:0] dp_in2;
   logic        busy;
   logic        stall;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic [31:0] mf_data;

   modport master (
      output op_valid, md_op, rs_val, rt_val,
      output flush, dp_hi, dp_lo,
      input  dp_start, dp_op, dp_in1, dp_in2,
      input  busy, stall, hi_out, lo_out, mf_data
   );

   modport slave (
      input  op_valid, md_op, rs_val, rt_val,
      input  flush, dp_hi, dp_lo,
      output dp_start, dp_op, dp_in1, dp_in2,
      output busy, stall, hi_out, lo_out, mf_data
   );
endinterface

// File: rtl/md_ctrl.sv
// HI/LO register file and multi-cycle mult/div
// sequencer with pipeline stall generation.
module md_ctrl #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input logic        clk,
   input logic        reset,
   md_ctrl_if.slave   bus
);
   localparam int MAX_LAT =
      (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW = $clog2(MAX_LAT + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    op_q;
   logic          busy_q;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;
   logic          accept;
   logic          issue;
   logic          done;

   assign accept = bus.op_valid & ~busy_q & ~bus.flush;
   assign issue  = accept & ~bus.md_op[2] & ~reset;
   assign done   = (cnt == CW'(1));

   assign bus.dp_start = issue;
   // Hold the in-flight op toward the datapath while running
   assign bus.dp_op    = busy_q ? op_q : bus.md_op[1:0];
   assign bus.dp_in1   = bus.rs_val;
   assign bus.dp_in2   = bus.rt_val;
   assign bus.busy     = busy_q;
   assign bus.stall    = bus.op_valid & busy_q;
   assign bus.hi_out   = hi_q;
   assign bus.lo_out   = lo_q;

   always_comb begin
      bus.mf_data = '0;
      unique case (1'b1)
         (bus.md_op == 3'd6): bus.mf_data = hi_q;
         (bus.md_op == 3'd7): bus.mf_data = lo_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= '0;
         busy_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (issue) begin
                  state  <= RUN;
                  busy_q <= 1'b1;
                  op_q   <= bus.md_op[1:0];
                  cnt    <= bus.md_op[1] ? CW'(DIV_LAT)
                                         : CW'(MULT_LAT);
               end else if (accept && bus.md_op == 3'd4) begin
                  hi_q <= bus.rs_val;
               end else if (accept && bus.md_op == 3'd5) begin
                  lo_q <= bus.rs_val;
               end
            end
            RUN: begin
               cnt <= cnt - CW'(1);
               if (done) begin
                  hi_q   <= bus.dp_hi;
                  lo_q   <= bus.dp_lo;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_md_ctrl.sv
// Bench for md_ctrl: directed scenarios plus
// random traffic against a remaining-cycles model.
module tb_md_ctrl;
   localparam int ML = 5;
   localparam int DL = 10;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   n_start;

   int          m_rem;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   md_ctrl_if bus();

   md_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (bus.dp_start) n_start++;

   task automatic set(
      input logic v, input logic [2:0] op,
      input logic [31:0] rs, input logic [31:0] rt,
      input logic fl, input logic rst,
      input logic [31:0] dh, input logic [31:0] dl);
      bus.op_valid = v;
      bus.md_op    = op;
      bus.rs_val   = rs;
      bus.rt_val   = rt;
      bus.flush    = fl;
      reset        = rst;
      bus.dp_hi    = dh;
      bus.dp_lo    = dl;
      #1;
   endtask

   // Model: HI/LO pair plus cycles of busy remaining
   task automatic tick();
      if (reset) begin
         m_rem = 0; m_hi = '0; m_lo = '0;
      end else if (m_rem > 0) begin
         if (m_rem == 1) begin
            m_hi = bus.dp_hi; m_lo = bus.dp_lo;
         end
         m_rem--;
      end else if (bus.op_valid && !bus.flush) begin
         case (bus.md_op)
            3'd0, 3'd1: m_rem = ML;
            3'd2, 3'd3: m_rem = DL;
            3'd4: m_hi = bus.rs_val;
            3'd5: m_lo = bus.rs_val;
            default: ;
         endcase
      end
      @(negedge clk);
   endtask

   task automatic idle();
      set(0, 3'd0, $urandom, $urandom, 0, 0,
          $urandom, $urandom);
   endtask

   task automatic test_reset();
      set(1, 3'd0, 32'h5, 32'h6, 0, 1, 32'h1, 32'h2);
      total++;
      if (bus.dp_start !== 1'b0) begin
         bad++;
         $display("FAIL rst_start got=%b exp=0",
                  bus.dp_start);
      end
      tick();
      idle();
      total++;
      if (bus.busy !== 1'b0 || bus.hi_out !== 32'h0 ||
          bus.lo_out !== 32'h0 || bus.stall !== 1'b0) begin
         bad++;
         $display("FAIL rst_state got=%b %h %h exp=0 0 0",
                  bus.busy, bus.hi_out, bus.lo_out);
      end
      tick();
   endtask

   task automatic test_mult();
      set(1, 3'd0, 32'h3, 32'h4, 0, 0, 32'h9, 32'h9);
      total++;
      if (bus.dp_start !== 1'b1 || bus.dp_op !== 2'd0 ||
          bus.dp_in1 !== 32'h3 || bus.dp_in2 !== 32'h4) begin
         bad++;
         $display("FAIL mult_launch got=%b %0d %h %h",
                  bus.dp_start, bus.dp_op,
                  bus.dp_in1, bus.dp_in2);
      end
      tick();
      for (int k = 1; k <= ML; k++) begin
         set(0, 3'd0, $urandom, $urandom, 0, 0,
             (k == ML) ? 32'h1 : $urandom,
             (k == ML) ? 32'h2 : $urandom);
         total++;
         if (bus.busy !== 1'b1 || bus.dp_start !== 1'b0) begin
            bad++;
            $display("FAIL mult_busy k=%0d got=%b %b exp=1 0",
                     k, bus.busy, bus.dp_start);
         end
         tick();
      end
      idle();
      total++;
      if (bus.busy !== 1'b0 || bus.hi_out !== 32'h1 ||
          bus.lo_out !== 32'h2) begin
         bad++;
         $display("FAIL mult_commit got=%b %h %h exp=0 1 2",
                  bus.busy, bus.hi_out, bus.lo_out);
      end
      tick();
   endtask

   task automatic test_div_mf();
      logic [31:0] nlo;
      logic [31:0] nhi;
      nlo = $urandom;
      nhi = $urandom;
      set(1, 3'd2, $urandom, 32'h0, 0, 0, 0, 0);
      total++;
      if (bus.dp_start !== 1'b1 || bus.dp_op !== 2'd2) begin
         bad++;
         $display("FAIL div_launch got=%b %0d exp=1 2",
                  bus.dp_start, bus.dp_op);
      end
      tick();
      for (int k = 1; k <= DL; k++) begin
         if (k < 3)
            set(0, 3'd0, 0, 0, 0, 0, $urandom, $urandom);
         else
            set(1, 3'd7, 0, 0, 0, 0,
                (k == DL) ? nhi : $urandom,
                (k == DL) ? nlo : $urandom);
         total++;
         if (bus.stall !== (k >= 3)) begin
            bad++;
            $display("FAIL div_stall k=%0d got=%b",
                     k, bus.stall);
         end
         tick();
      end
      set(1, 3'd7, 0, 0, 0, 0, 0, 0);
      total++;
      if (bus.stall !== 1'b0 || bus.mf_data !== nlo ||
          bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL div_mflo got=%b %h exp=0 %h",
                  bus.stall, bus.mf_data, nlo);
      end
      tick();
      set(1, 3'd6, 0, 0, 0, 0, 0, 0);
      total++;
      if (bus.mf_data !== nhi || bus.stall !== 1'b0) begin
         bad++;
         $display("FAIL div_mfhi got=%h exp=%h",
                  bus.mf_data, nhi);
      end
      tick();
   endtask

   task automatic test_mthi();
      set(1, 3'd4, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      total++;
      if (bus.stall !== 1'b0 || bus.busy !== 1'b0 ||
          bus.dp_start !== 1'b0) begin
         bad++;
         $display("FAIL mthi_issue got=%b %b %b exp=0 0 0",
                  bus.stall, bus.busy, bus.dp_start);
      end
      tick();
      set(1, 3'd5, 32'h12345678, 0, 0, 0, 0, 0);
      total++;
      if (bus.hi_out !== 32'hDEADBEEF || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL mthi_val got=%h exp=deadbeef",
                  bus.hi_out);
      end
      tick();
      idle();
      total++;
      if (bus.lo_out !== 32'h12345678) begin
         bad++;
         $display("FAIL mtlo_val got=%h exp=12345678",
                  bus.lo_out);
      end
      tick();
   endtask

   task automatic test_flush();
      logic [31:0] h0;
      logic [31:0] l0;
      h0 = bus.hi_out;
      l0 = bus.lo_out;
      set(1, 3'd0, 1, 2, 1, 0, $urandom, $urandom);
      total++;
      if (bus.dp_start !== 1'b0 || bus.stall !== 1'b0) begin
         bad++;
         $display("FAIL flush_start got=%b %b exp=0 0",
                  bus.dp_start, bus.stall);
      end
      tick();
      set(1, 3'd4, 32'hAAAA5555, 0, 1, 0, 0, 0);
      tick();
      for (int k = 0; k < 3; k++) begin
         idle();
         total++;
         if (bus.busy !== 1'b0 || bus.hi_out !== h0 ||
             bus.lo_out !== l0) begin
            bad++;
            $display("FAIL flush_hold got=%b %h %h exp=0 %h %h",
                     bus.busy, bus.hi_out, bus.lo_out, h0, l0);
         end
         tick();
      end
   endtask

   task automatic test_reset_inflight();
      set(1, 3'd4, 32'h11, 0, 0, 0, 0, 0);
      tick();
      set(1, 3'd3, 7, 0, 0, 0, 0, 0);
      tick();
      for (int k = 1; k <= DL + 2; k++) begin
         set(0, 3'd0, 0, 0, 0, (k == 4),
             32'hFFFF0000, 32'h0000FFFF);
         if (k == 5) begin
            total++;
            if (bus.busy !== 1'b0 || bus.hi_out !== 32'h0 ||
                bus.lo_out !== 32'h0) begin
               bad++;
               $display("FAIL rst_flight got=%b %h %h exp=0 0 0",
                        bus.busy, bus.hi_out, bus.lo_out);
            end
         end
         tick();
      end
      idle();
      total++;
      if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin
         bad++;
         $display("FAIL rst_nocommit got=%h %h exp=0 0",
                  bus.hi_out, bus.lo_out);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int n0;
      n0 = n_start;
      set(1, 3'd1, 5, 6, 0, 0, 0, 0);
      tick();
      for (int k = 1; k <= ML; k++) begin
         set(1, 3'd0, 8, 9, 0, 0,
             (k == ML) ? 32'hC0DE : 32'h0,
             (k == ML) ? 32'hBEEF : 32'h0);
         total++;
         if (bus.stall !== 1'b1 || bus.dp_start !== 1'b0) begin
            bad++;
            $display("FAIL b2b_stall k=%0d got=%b %b exp=1 0",
                     k, bus.stall, bus.dp_start);
         end
         tick();
      end
      set(1, 3'd0, 8, 9, 0, 0, 0, 0);
      total++;
      if (bus.stall !== 1'b0 || bus.dp_start !== 1'b1 ||
          bus.hi_out !== 32'hC0DE) begin
         bad++;
         $display("FAIL b2b_launch got=%b %b %h exp=0 1 c0de",
                  bus.stall, bus.dp_start, bus.hi_out);
      end
      tick();
      for (int k = 0; k < ML + 1; k++) begin
         idle();
         tick();
      end
      total++;
      if (n_start - n0 !== 2) begin
         bad++;
         $display("FAIL b2b_count got=%0d exp=2", n_start - n0);
      end
   endtask

   task automatic test_random();
      logic        v;
      logic [2:0]  op;
      logic        fl;
      logic        rst;
      logic        e_start;
      logic [31:0] e_mf;
      for (int i = 0; i < 600; i++) begin
         v   = ($urandom_range(0, 9) < 4);
         op  = 3'($urandom_range(0, 7));
         fl  = ($urandom_range(0, 9) == 0);
         rst = ($urandom_range(0, 63) == 0);
         set(v, op, $urandom, $urandom, fl, rst,
             $urandom, $urandom);
         e_start = v && m_rem == 0 && !fl &&
                   op < 3'd4 && !rst;
         e_mf = (op == 3'd6) ? m_hi :
                (op == 3'd7) ? m_lo : 32'h0;
         total++;
         if (bus.dp_start !== e_start ||
             bus.stall !== (v && m_rem > 0) ||
             bus.busy !== (m_rem > 0)) begin
            bad++;
            $display("FAIL rnd_ctl i=%0d got=%b%b%b rem=%0d",
                     i, bus.dp_start, bus.stall,
                     bus.busy, m_rem);
         end
         total++;
         if (bus.hi_out !== m_hi || bus.lo_out !== m_lo ||
             bus.mf_data !== e_mf) begin
            bad++;
            $display("FAIL rnd_reg i=%0d got=%h %h %h exp=%h %h %h",
                     i, bus.hi_out, bus.lo_out, bus.mf_data,
                     m_hi, m_lo, e_mf);
         end
         tick();
      end
   endtask

   initial begin
      total = 0; bad = 0; n_start = 0;
      m_rem = 0; m_hi = '0; m_lo = '0;
      reset = 1'b1;
      bus.op_valid = 0; bus.md_op = 0;
      bus.rs_val = 0; bus.rt_val = 0;
      bus.flush = 0; bus.dp_hi = 0; bus.dp_lo = 0;
      @(negedge clk);
      set(0, 3'd0, 0, 0, 0, 1, 0, 0);
      tick();
      test_reset();
      test_mult();
      test_div_mf();
      test_mthi();
      test_flush();
      test_reset_inflight();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
